// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state type, state encodings and operand extension helper for seq_mult
// Contents: state_t (IDLE/RUN/DONE, 2 bits), ENC_* encodings, extend() for zero/sign extension to 2*WIDTH
package seq_mult_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_RUN  = 2'd1;
    localparam logic [1:0] ENC_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        RUN  = ENC_RUN,
        DONE = ENC_DONE
    } state_t;

    // Extends a w-bit value (w <= 32) to 64 bits; callers keep the low 2*WIDTH bits.
    function automatic logic [63:0] extend(input logic [31:0] v, input int unsigned w, input logic sgn);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (sgn && v[5'(w - 1)]) ? (({32'd0, v} & mask) | ~mask) : ({32'd0, v} & mask);
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: valid/ready operand and result bus of seq_mult
// Signals: in_valid/in_ready/a/b/sign_mode (operand side), out_valid/out_ready/x (result side)
// Modports: master drives operands and accepts results, slave is the multiplier
interface seq_mult_if #(parameter int WIDTH = 8);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 sign_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   x;

    modport master (
        output in_valid, a, b, sign_mode, out_ready,
        input  in_ready, out_valid, x
    );

    modport slave (
        input  in_valid, a, b, sign_mode, out_ready,
        output in_ready, out_valid, x
    );

endinterface

// File: rtl/seq_mult_sign_fix.sv
// mult_sign_fix: combinational conditional two's-complement negate (magnitude or result sign fix)
// Ports: v (N-bit operand), neg (negate when high), y (N-bit result)
module mult_sign_fix #(
    parameter int N = 8
) (
    input  logic [N-1:0] v,
    input  logic         neg,
    output logic [N-1:0] y
);

    // Magnitude of -2^(N-1) wraps to 2^(N-1), which is the correct unsigned magnitude.
    assign y = neg ? (~v + N'(1)) : v;

endmodule

// File: rtl/seq_mult.sv
// seq_mult: multi-cycle shift-add multiplier, one partial-product bit per clock, full 2*WIDTH product
// Ports: clk, rst (async active-high), bus (seq_mult_if.slave: in_valid/in_ready/a/b/sign_mode, out_valid/out_ready/x)
// Build option: SEQ_MULT_SIGNED_EN enables two's-complement operation selected by sign_mode; otherwise sign_mode is ignored
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult_if.slave     bus
);

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   mcand, acc, acc_nx, x_nx, x_q;
    logic [WIDTH-1:0]     mplier, a_mag, b_mag;
    logic [CNT_W-1:0]     cnt;
    logic                 accept, last;

    assign accept = bus.in_valid && state == IDLE;
    assign last   = cnt == CNT_W'(WIDTH - 1);
    assign acc_nx = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
    logic neg, neg_nx;

    // Operands become magnitudes at accept; the product sign is restored on the DONE-entry edge.
    mult_sign_fix #(.N(WIDTH)) u_fix_a (
        .v   (bus.a),
        .neg (bus.sign_mode && bus.a[WIDTH-1]),
        .y   (a_mag)
    );

    mult_sign_fix #(.N(WIDTH)) u_fix_b (
        .v   (bus.b),
        .neg (bus.sign_mode && bus.b[WIDTH-1]),
        .y   (b_mag)
    );

    mult_sign_fix #(.N(2*WIDTH)) u_fix_x (
        .v   (acc_nx),
        .neg (neg),
        .y   (x_nx)
    );

    assign neg_nx = bus.sign_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            neg <= 1'b0;
        else if (accept)
            neg <= neg_nx;
    end
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
    assign x_nx  = acc_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == DONE;
        bus.x         = x_q;
        if (state == IDLE && bus.in_valid)
            state_nx = RUN;
        else if (state == RUN && last)
            state_nx = DONE;
        else if (state == DONE && bus.out_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            x_q    <= '0;
        end else if (accept) begin
            mcand  <= (2*WIDTH)'(extend(32'(a_mag), WIDTH, 1'b0));
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last)
                x_q <= x_nx;
        end
    end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised multi-cycle shift-add multiplier; successor to the 8x8 combinational multiplier.
- Trades latency for area: one partial-product bit per clock.
- Valid/ready handshake on both sides, so it drops into pipelined datapaths with backpressure.
- Product is full width, 2*WIDTH bits, never truncated.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operands a/b (and sign_mode) are presented.
- in_ready, output, 1, block can accept operands (high only in IDLE).
- a, input, WIDTH, multiplicand.
- b, input, WIDTH, multiplier.
- sign_mode, input, 1, 1 = treat a/b as two's complement. Ignored (tie-off) without SEQ_MULT_SIGNED_EN.
- out_valid, output, 1, x holds a valid product.
- out_ready, input, 1, downstream accepts x.
- x, output, 2*WIDTH, product.

Behaviour:
- Reset (async assert, sync-safe deassert by integrator):
  - state=IDLE, in_ready=1, out_valid=0, x=0.
  - Internal accumulator, multiplier shift register and counter cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&&in_ready: latch a (zero-extended to 2*WIDTH) and b, clear accumulator, counter=0, go to RUN.
  - in_valid without acceptance has no effect.
- RUN:
  - in_ready=0.
  - Each edge: if multiplier LSB=1, accumulator += shifted multiplicand.
  - Multiplicand shifts left 1, multiplier shifts right 1, counter++.
  - After exactly WIDTH RUN edges go to DONE, and x=accumulator is registered on that edge.
- Latency: out_valid is first high in the cycle after edge T0+WIDTH, where T0 is the accept edge (8 cycles for WIDTH=8). Latency is fixed and independent of operand values.
- DONE:
  - out_valid=1; x stable until the handshake.
  - On the edge with out_valid&&out_ready: go to IDLE, out_valid=0.
  - x keeps its last value after the handshake; consumers must not sample it without out_valid.
- No overlap: a new operand is accepted only from IDLE, so there is at least one idle cycle between a result handshake and the next accept. Maximum throughput is 1 product per WIDTH+2 cycles.
- Inputs a/b/sign_mode may change freely after acceptance; the block works only on latched copies.
- Arithmetic:
  - Unsigned result is exact: x = a*b mod 2^(2*WIDTH), with no overflow possible.
  - Worst case (2^WIDTH-1)^2 fits.
- Boundaries:
  - a=0 or b=0 still takes the full WIDTH cycles and gives x=0.
  - out_ready held high in DONE gives a single-cycle out_valid pulse.
  - rst asserted mid-RUN or in DONE aborts the operation immediately; the result is discarded and out_valid falls asynchronously.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - sign_mode is latched at accept.
  - If sign_mode=1, the operands are converted to magnitudes on accept, the unsigned core runs, and the result is two's-complement negated on the DONE-entry edge when the sign bits differ.
  - Latency is unchanged.
  - -2^(WIDTH-1) squared (e.g. -128*-128=16384=0x4000) must be exact.
- Not defined:
  - sign_mode port is present but ignored.
  - All operations are unsigned.
  - No negation logic is synthesised.

Decomposition:
- Package seq_mult_pkg holds:
  - state typedef (enum IDLE/RUN/DONE, 2 bits).
  - localparam encodings.
  - a function for the 2*WIDTH zero/sign extension.
- One natural sub-module, mult_sign_fix: combinational magnitude/negate helper. It is instantiated only under SEQ_MULT_SIGNED_EN; it takes a WIDTH or 2*WIDTH operand plus a negate flag.
- The FSM and datapath stay in seq_mult.

Test Plan:
- Reset then a=0x02, b=0x01, in_valid for 1 cycle -> in_ready drops next cycle; out_valid rises 8 cycles after accept; x=0x0002.
- a=0xFF, b=0xFF, out_ready=0 for 5 cycles after out_valid -> x=0xFE01 held stable with out_valid=1 for all 5 cycles; out_ready=1 -> IDLE next cycle.
- Back-to-back: 2*2 then 3*5 with in_valid held high -> first x=0x0004, second x=0x000F; second accept only after return to IDLE; no lost or duplicated results.
- a=0x00, b=0xFF -> x=0x0000 after exactly 8 cycles; a changed to 0x55 during RUN -> result unaffected.
- rst pulse at RUN cycle 4 of 0x10*0x10 -> out_valid stays 0, x=0, in_ready=1 immediately. Next op 0x10*0x10 -> x=0x0100.
- With SEQ_MULT_SIGNED_EN, sign_mode=1:
  - -1*1 (0xFF,0x01) -> x=0xFFFF.
  - -128*-128 (0x80,0x80) -> x=0x4000.
  - -3*5 -> x=0xFFF1.
  - With sign_mode=0, 0xFF*0x01 -> x=0x00FF.
